// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson sequencer with direction, parallel load and wrap pulse.
// Optional illegal-state self-correction is enabled by defining RING_SELF_CORRECT_EN.
module ring_counter_gen #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             err
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] shift_nxt;

  // Johnson feedback is the ring feedback inverted, so mode simply XORs the wrapped bit.
  always_comb begin
    shift_nxt = cnt_q;
    if (dir) shift_nxt = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1] ^ mode};
    else     shift_nxt = {cnt_q[0] ^ mode, cnt_q[WIDTH-1:1]};
  end

`ifdef RING_SELF_CORRECT_EN
  logic             err_q, err_d;
  logic [5:0]       ones_cnt;
  logic [5:0]       edge_cnt;
  logic [WIDTH-1:0] edges;
  logic             illegal;

  // A single circular run of ones has exactly two boundaries, or none when all-0/all-1.
  always_comb begin
    ones_cnt = '0;
    edge_cnt = '0;
    edges    = cnt_q ^ {cnt_q[0], cnt_q[WIDTH-1:1]};
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + 6'(cnt_q[i]);
      edge_cnt = edge_cnt + 6'(edges[i]);
    end
    if (mode) illegal = !((edge_cnt == 6'd0) || (edge_cnt == 6'd2));
    else      illegal = (ones_cnt != 6'd1);
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
`ifdef RING_SELF_CORRECT_EN
    err_d = 1'b0;
`endif
    if (load) begin
      cnt_d = load_val;
    end
`ifdef RING_SELF_CORRECT_EN
    else if (illegal) begin
      cnt_d = RST_VAL;
      err_d = 1'b1;
    end
`endif
    else if (en) begin
      cnt_d = shift_nxt;
      tc_d  = (shift_nxt == RST_VAL) && (cnt_q != RST_VAL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
`ifdef RING_SELF_CORRECT_EN
      err_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
`ifdef RING_SELF_CORRECT_EN
      err_q <= err_d;
`endif
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
`ifdef RING_SELF_CORRECT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_counter_gen.sv
// Scoreboard bench for ring_counter_gen: WIDTH=4 default instance plus a WIDTH=8 Johnson instance.
module tb_ring_counter_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, mode, dir, en8;
  logic [3:0] load_val, cnt;
  logic [7:0] cnt8;
  logic       tc, err, tc8, err8;

  always #5 clk = ~clk;

  ring_counter_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .dir(dir), .cnt(cnt), .tc(tc), .err(err)
  );

  ring_counter_gen #(.WIDTH(8), .RST_VAL(8'h01)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(1'b0), .load_val(8'h00),
    .mode(1'b1), .dir(1'b1), .cnt(cnt8), .tc(tc8), .err(err8)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed { logic [3:0] c; logic t; logic e; } exp_t;
  exp_t q[$];
  logic q8[$];

  localparam logic [3:0] RV = 4'b1000;
  logic [3:0] m_cnt;

`ifdef RING_SELF_CORRECT_EN
  function automatic logic legal(input logic [3:0] c, input logic m);
    int ones, trans;
    ones = 0; trans = 0;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) ones++;
      if (c[i] != c[(i + 1) % 4]) trans++;
    end
    return m ? (trans == 0 || trans == 2) : (ones == 1);
  endfunction
`endif

  // Model one edge, push the expectation, then pop and compare after the edge.
  task automatic cyc(input logic ld, input logic e, input logic [3:0] lv,
                     input logic m, input logic d, input string tag);
    exp_t x;
    logic [3:0] n;
    load = ld; en = e; load_val = lv; mode = m; dir = d;
    x.t = 1'b0; x.e = 1'b0; n = m_cnt;
    if (ld) n = lv;
`ifdef RING_SELF_CORRECT_EN
    else if (!legal(m_cnt, m)) begin n = RV; x.e = 1'b1; end
`endif
    else if (e) begin
      for (int i = 0; i < 4; i++) begin
        if (d) n[i] = (i == 0) ? (m ? ~m_cnt[3] : m_cnt[3]) : m_cnt[i-1];
        else   n[i] = (i == 3) ? (m ? ~m_cnt[0] : m_cnt[0]) : m_cnt[i+1];
      end
      x.t = (n == RV) && (m_cnt != RV);
    end
    x.c = n;
    m_cnt = n;
    q.push_back(x);
    @(posedge clk); #1;
    x = q.pop_front();
    chk({tag, ".cnt"}, 32'(cnt), 32'(x.c));
    chk({tag, ".tc"},  32'(tc),  32'(x.t));
    chk({tag, ".err"}, 32'(err), 32'(x.e));
  endtask

  logic [3:0] ring_tbl [4];
  logic [3:0] john_tbl [8];

  initial begin
    int steps;
    logic [7:0] ab;
    ring_tbl = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    john_tbl = '{4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0; dir = 1'b0; en8 = 1'b0;
    m_cnt = RV;
    #12;
    chk("rst.cnt", 32'(cnt), 32'(RV));
    chk("rst.tc", 32'(tc), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.cnt8", 32'(cnt8), 32'h01);
    @(negedge clk) rst = 1'b1;

    // Ring toward LSB, tc on the wrap back to 1000 only.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, "ring_r");
      chk("ring_r.tbl", 32'(cnt), 32'(ring_tbl[i]));
      chk("ring_r.tcv", 32'(tc), (i == 3) ? 32'd1 : 32'd0);
    end

    // Johnson toward LSB: eight steps per period.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, "john_r");
      chk("john_r.tbl", 32'(cnt), 32'(john_tbl[i]));
    end

    // Ring toward MSB with a three-cycle hold in the middle.
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "ring_l");
    chk("ring_l.first", 32'(cnt), 32'b0001);
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "ring_l");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, "hold");
    chk("hold.cnt", 32'(cnt), 32'b0010);
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "ring_l");
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "ring_l");
    chk("ring_l.wrap", 32'(tc), 1);

    // Load beats enable.
    cyc(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, "load");
    chk("load.val", 32'(cnt), 32'b0010);

    // Illegal ring value: kept and rotated, or corrected with err when the checker is built in.
    cyc(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, "ld_bad");
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, "bad_step");
`ifdef RING_SELF_CORRECT_EN
    chk("bad_step.fix", 32'(cnt), 32'b1000);
    chk("bad_step.errv", 32'(err), 1);
`else
    chk("bad_step.rot", 32'(cnt), 32'b0011);
    chk("bad_step.errv", 32'(err), 0);
`endif

    // Asynchronous reset mid-cycle, observed before the next edge.
    #3 rst = 1'b0;
    #1;
    chk("arst.cnt", 32'(cnt), 32'(RV));
    chk("arst.tc", 32'(tc), 0);
    chk("arst.err", 32'(err), 0);
    m_cnt = RV;
    @(negedge clk) rst = 1'b1;
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, "post_rst");
    chk("post_rst.tbl", 32'(cnt), 32'b0100);

    // WIDTH=8 Johnson toward MSB from 01: tc every 16 enabled clocks, never while idle.
    steps = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++) begin
      en8 = ($urandom_range(0, 3) != 0);
      if (en8) begin
        steps++;
        q8.push_back((steps % 16) == 0);
      end else begin
        q8.push_back(1'b0);
      end
      @(posedge clk); #1;
      chk("w8.tc", 32'(tc8), 32'(q8.pop_front()));
      chk("w8.err", 32'(err8), 0);
    end
    // Final state from the step count: a run of ones growing from bit 0, then draining.
    ab = '0;
    for (int k = 0; k < 8; k++) begin
      int p;
      p = (steps % 16);
      if (p < 8) ab[k] = (k <= p);
      else       ab[k] = (k > p - 8);
    end
    chk("w8.cnt", 32'(cnt8), 32'(ab));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
